// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: double-dabble BCD conversion of a 14-bit count, shown on a 4-digit multiplexed active-low 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 25000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);
    localparam int CW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        r_state, w_state_next;
    logic [13:0]   r_last_value, r_shift;
    logic [15:0]   r_bcd, r_disp, w_bcd_adj;
    logic          r_ovf;
    logic [3:0]    r_shift_cnt;
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_idx, w_idx_next;
    logic          w_wrap, w_blank;
    logic [3:0]    w_digit;
    logic [6:0]    r_seg, w_pat, w_seg_next;

    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3 : r_bcd[4*g +: 4];
    end

    // Conversion state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: wait for a new value, shift 14 times, then one DONE cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = (value != r_last_value) ? SHIFT : IDLE;
            SHIFT:   w_state_next = (r_shift_cnt == 4'd13) ? DONE : SHIFT;
            default: w_state_next = IDLE;
        endcase
    end

    // Conversion datapath; the display register only changes in DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_value <= '0;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_shift_cnt  <= '0;
            r_disp       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (value != r_last_value) begin
                    r_last_value <= value;
                    r_shift      <= value;
                    r_bcd        <= '0;
                    r_shift_cnt  <= '0;
                end
                SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_shift_cnt      <= r_shift_cnt + 4'd1;
                end
                DONE: begin
                    r_disp <= r_bcd;
                    r_ovf  <= r_last_value > 14'd9999;
                end
                default: ;
            endcase
        end
    end

    assign w_wrap     = r_refresh == CW'(REFRESH_DIV - 1);
    assign w_idx_next = r_idx + {1'b0, w_wrap};
    assign w_digit    = r_disp[4*w_idx_next +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (w_idx_next != 2'd0) && ((r_disp >> {w_idx_next, 2'b00}) == 16'd0);
`else
    assign w_blank = 1'b0;
`endif

    // Digit pattern lookup; nibble codes above 9 are blank
    always_comb begin
        w_pat = 7'b1111111;
        case (w_digit)
            4'd0:    w_pat = 7'b1000000;
            4'd1:    w_pat = 7'b1111001;
            4'd2:    w_pat = 7'b0100100;
            4'd3:    w_pat = 7'b0110000;
            4'd4:    w_pat = 7'b0011001;
            4'd5:    w_pat = 7'b0010010;
            4'd6:    w_pat = 7'b0000010;
            4'd7:    w_pat = 7'b1111000;
            4'd8:    w_pat = 7'b0000000;
            4'd9:    w_pat = 7'b0010000;
            default: w_pat = 7'b1111111;
        endcase
    end

    assign w_seg_next = r_ovf ? 7'b0111111 : (w_blank ? 7'b1111111 : w_pat);

    // Free-running scan; seg is decoded for the next index so it changes together with an
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= 7'b1000000;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
            r_idx     <= w_idx_next;
            r_seg     <= w_seg_next;
        end
    end

    assign an   = 4'b1111 ^ (4'b0001 << r_idx);
    assign seg  = r_seg;
    assign dp   = 1'b1;
    assign busy = r_state != IDLE;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: table-driven, directed and random checks of the scan driver against a behavioural display model.
module tb_seven_seg_scan_driver;
    localparam int DIV = 4;
    localparam logic [6:0] DASH = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic        clock, reset;
    logic [13:0] value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, busy;

    seven_seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .value(value),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0, n_fail = 0;
    int m_n, m_last, m_busy_left, m_disp, m_idx;
    logic [6:0] m_seg;
    logic [6:0] pats [10];
    int pow10 [4];

    typedef struct {
        logic [13:0]     v;
        logic [3:0][6:0] s;
    } vec_t;
    vec_t tbl [8];

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] exp_seg(int d, int idx);
        if (d > 9999) return DASH;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && d < pow10[idx]) return 7'b1111111;
`endif
        return pats[(d / pow10[idx]) % 10];
    endfunction

    function automatic void model_reset();
        m_n = 0; m_last = 0; m_busy_left = 0; m_disp = 0; m_idx = 0; m_seg = 7'b1000000;
    endfunction

    // One clock: advance the model across the rising edge, then compare on the falling edge
    task automatic step();
        int nidx;
        @(posedge clock);
        m_n++;
        nidx = (m_n / DIV) % 4;
        m_seg = exp_seg(m_disp, nidx);
        if (m_busy_left == 0) begin
            if (int'(value) != m_last) begin
                m_last = int'(value);
                m_busy_left = 15;
            end
        end else begin
            m_busy_left--;
            if (m_busy_left == 0) m_disp = m_last;
        end
        m_idx = nidx;
        @(negedge clock);
        chk("an", an, 4'b1111 ^ (4'b0001 << m_idx));
        chk("seg", seg, m_seg);
        chk("busy", busy, m_busy_left != 0);
        chk("dp", dp, 1'b1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_an"}, an, 4'b1110);
        chk({tag, "_seg"}, seg, 7'b1000000);
        chk({tag, "_dp"}, dp, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int cnt;
        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        pow10 = '{1, 10, 100, 1000};
        tbl[0] = '{14'd1234,  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[1] = '{14'd10000, {DASH, DASH, DASH, DASH}};
        tbl[2] = '{14'd7,     {LZ, LZ, LZ, 7'b1111000}};
        tbl[3] = '{14'd0,     {LZ, LZ, LZ, 7'b1000000}};
        tbl[4] = '{14'd9999,  {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
        tbl[5] = '{14'd5060,  {7'b0010010, 7'b1000000, 7'b0000010, 7'b1000000}};
        tbl[6] = '{14'd80,    {LZ, LZ, 7'b0000000, 7'b1000000}};
        tbl[7] = '{14'd16383, {DASH, DASH, DASH, DASH}};

        reset = 1'b1;
        value = '0;
        model_reset();
        #1 chk_reset_outputs("por");
        @(negedge clock);
        reset = 1'b0;

        // Idle scan with value held at zero
        repeat (20) step();

        // 0 -> 1234: busy width and display latency
        value = 14'd1234;
        step();
        cnt = 0;
        for (int k = 0; k < 40 && busy; k++) begin step(); cnt++; end
        chk("busy_len", cnt, 15);
        repeat (4) step();

        // Table of values: settle, then check every slot for a full scan
        for (int t = 0; t < 8; t++) begin
            value = tbl[t].v;
            repeat (20) step();
            for (int k = 0; k < 4 * DIV; k++) begin
                step();
                chk($sformatf("tbl%0d_slot%0d", t, m_idx), seg, tbl[t].s[m_idx]);
            end
        end

        // Value changes during SHIFT: first result shows, then a fresh conversion
        value = 14'd1234;
        step();
        repeat (5) step();
        value = 14'd5678;
        cnt = 0;
        for (int k = 0; k < 40 && busy; k++) begin step(); cnt++; end
        chk("busy_tail", cnt, 10);
        step();
        chk("recapture", busy, 1'b1);
        cnt = 0;
        for (int k = 0; k < 40 && busy; k++) begin step(); cnt++; end
        chk("busy_len2", cnt, 15);
        repeat (20) step();

        // Reset in the middle of a 9999 conversion
        value = 14'd9999;
        step();
        repeat (6) step();
        #2 reset = 1'b1;
        value = '0;
        model_reset();
        #1 chk_reset_outputs("mid");
        @(posedge clock);
        #1 chk_reset_outputs("hold");
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            chk("no_conv", busy, 1'b0);
        end

        // Random values and hold times
        for (int r = 0; r < 40; r++) begin
            int h;
            case ($urandom_range(0, 3))
                0:       value = 14'($urandom_range(10000, 16383));
                1:       value = 14'($urandom_range(0, 99));
                default: value = 14'($urandom_range(0, 9999));
            endcase
            h = $urandom_range(1, 25);
            repeat (h) step();
        end
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
